slave_in_port: RTL
==================

# slave_in_port

Slave-side bus port that consumes the serial transaction stream driven by a master output port once the arbiter has granted the bus. It deserialises the LSB-first address and data bit streams and issues a single parallel write or read to the local slave memory. For reads, it serialises the returned word back to the master. It sits between the bus interconnect (master/arbiter side) and the slave's memory.

## Interface
Parameters:
- ADDR_LEN, 12, address width in bits (serial address length).
- DATA_LEN, 8, data width in bits (serial data length).
- MEM_DEPTH, 4096, number of valid memory words (used only with address check).

Ports:
- clk  input  1  bus clock; all state changes on the rising edge.
- reset  input  1  reset, asynchronous, active-low.
- master_valid  input  1  master presents a transaction.
- write_en  input  1  transaction is a write.
- read_en  input  1  transaction is a read.
- rx_address  input  1  serial address bit, LSB first.
- rx_data  input  1  serial write-data bit, LSB first.
- slave_ready  output  1  port idle and able to accept a handshake.
- mem_addr  output  ADDR_LEN  parallel address to memory.
- mem_wdata  output  DATA_LEN  parallel write data to memory.
- mem_we  output  1  one-cycle memory write strobe.
- mem_re  output  1  one-cycle memory read strobe.
- mem_rdata  input  DATA_LEN  memory read data.
- mem_rvalid  input  1  mem_rdata valid this cycle.
- slave_valid  output  1  read data being returned.
- tx_rdata  output  1  serial read-data bit, LSB first.
- master_ready  input  1  master accepts returned read data.
- addr_error  output  1  one-cycle pulse marking a rejected out-of-range address.

## Operation
- States:
  - IDLE: slave_ready=1.
  - RX: slave_ready=0.
  - WRITE_MEM.
  - READ_REQ.
  - READ_WAIT.
  - TX_READ.
- Handshake: a rising edge with master_valid=1, slave_ready=1 and exactly one of write_en/read_en high. On that edge:
  - mode is latched;
  - bit 0 of address and data is sampled;
  - counter is set to 1;
  - IDLE→RX.
- Both enables high, or neither high: no handshake; the port stays in IDLE.
- RX: samples one bit per cycle into shift registers at index counter. N = max(ADDR_LEN, DATA_LEN) bits are taken in total.
  - Address bits at index ≥ ADDR_LEN and data bits at index ≥ DATA_LEN are ignored.
  - Data bits are captured but unused for reads.
- master_valid=0 during RX: abort to IDLE. Counter is cleared and no memory access is made.
- After bit N-1 is sampled, go to WRITE_MEM (write) or READ_REQ (read).
- WRITE_MEM: mem_we=1 for one cycle with mem_addr/mem_wdata stable, then IDLE.
- READ_REQ: mem_re=1 for one cycle, then READ_WAIT.
- READ_WAIT: capture mem_rdata when mem_rvalid=1 (mem_rvalid coincident with mem_re is also accepted), then TX_READ.
- TX_READ:
  - slave_valid=1 and tx_rdata=bit 0, held until master_ready=1 (handshake edge T).
  - Bit k is then driven during cycle T+k, unconditionally, for k=1..DATA_LEN-1.
  - After the last bit: slave_valid=0 and the port returns to IDLE.
- mem_addr/mem_wdata hold their last values outside strobes.

## Timing
- Reset values: slave_ready=1; mem_we, mem_re, slave_valid, tx_rdata and addr_error are 0; mem_addr and mem_wdata are 0; state=IDLE; counter=0.
- Reset asserted mid-operation: immediate return to reset values, with no pending strobe.
- Handshake at edge H:
  - slave_ready=0 from H.
  - Last bit sampled at edge H+N-1.
  - Strobe high in cycle H+N.
  - Write: slave_ready=1 again from H+N+1.
- Read:
  - mem_re in cycle H+N.
  - slave_valid rises the cycle after mem_rvalid is seen.
  - Return stream is DATA_LEN cycles after the master_ready handshake.
- The master must hold master_valid through the N receive cycles.
- The counter saturates at N-1. It never wraps.

## Configuration
- SLAVE_ADDR_CHECK_EN defined: at the end of RX, an address ≥ MEM_DEPTH gives the following instead of a strobe:
  - addr_error pulses for one cycle;
  - a write is dropped, and the port returns to IDLE;
  - a read skips memory and returns an all-zero word through TX_READ.
- SLAVE_ADDR_CHECK_EN undefined: no check is made, all addresses reach memory, and addr_error is tied to 0.

## Structure
- Shared package holds:
  - state encoding constants (IDLE..TX_READ);
  - bus mode constants shared with the master port (INACTIVE=2'b00, WRITE=2'b10, READ=2'b11);
  - default ADDR_LEN/DATA_LEN.
- One natural sub-module: slave_read_serializer, which handles the TX_READ load, hold-until-master_ready and shift-out.

## Test plan
- Write addr=12'h0A5, data=8'h3C: after handshake, 12 bits are received, then mem_we is high for exactly 1 cycle with mem_addr=0A5 and mem_wdata=3C, and slave_ready=1 on the next cycle.
- Read addr=12'h123, memory returns 8'hA6 two cycles after mem_re: mem_re is high for 1 cycle; slave_valid holds with tx_rdata=0 until master_ready; then the bits stream out as 0,1,1,0,0,1,0,1.
- write_en=read_en=1 with master_valid=1: slave_ready stays 1, and there are no strobes.
- master_valid dropped at bit 5 of a write: the port returns to IDLE, and mem_we is never asserted.
- reset driven low during READ_WAIT: all outputs reach reset values immediately, and the next write completes normally.
- SLAVE_ADDR_CHECK_EN with MEM_DEPTH=2048, write to 12'h900: addr_error pulses once, and mem_we stays 0.

Source files
------------

// File: rtl/slave_in_port_pkg.sv
// Shared definitions for the slave-side bus input port: FSM state encoding,
// bus mode codes common with the master output port, and default widths.
package slave_in_port_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_RX        = 3'd1,
      S_WRITE_MEM = 3'd2,
      S_READ_REQ  = 3'd3,
      S_READ_WAIT = 3'd4,
      S_TX_READ   = 3'd5
   } state_e;

   // Bus mode codes, identical to the ones the master port drives.
   localparam logic [1:0] MODE_INACTIVE = 2'b00;
   localparam logic [1:0] MODE_WRITE    = 2'b10;
   localparam logic [1:0] MODE_READ     = 2'b11;

   localparam int ADDR_LEN_DEF = 12;
   localparam int DATA_LEN_DEF = 8;

   function automatic int max_len(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/slave_read_serializer.sv
// Read-return serializer: loads a word, holds bit 0 with valid high until the
// master accepts, then shifts the remaining bits out LSB first, one per cycle.
module slave_read_serializer #(
   parameter int DATA_LEN = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load_i,
   input  logic [DATA_LEN-1:0] load_data_i,
   input  logic                master_ready_i,
   output logic                slave_valid_o,
   output logic                tx_rdata_o,
   output logic                done_o
);

   localparam int CW = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
   localparam logic [CW-1:0] BIT_LAST = CW'(DATA_LEN - 1);

   logic [DATA_LEN-1:0] sh_q;
   logic                valid_q;
   logic                run_q;
   logic [CW-1:0]       cnt_q;

   // Load / hold-until-accepted / shift-out sequencing of the return word.
   // The acceptance edge does not shift, so bit 0 stays on the wire for one
   // more cycle and bit k lands k cycles after the handshake.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sh_q    <= '0;
         valid_q <= 1'b0;
         run_q   <= 1'b0;
         cnt_q   <= '0;
      end else if (load_i) begin
         sh_q    <= load_data_i;
         valid_q <= 1'b1;
         run_q   <= 1'b0;
         cnt_q   <= '0;
      end else if (run_q) begin
         if (cnt_q == BIT_LAST) begin
            sh_q    <= '0;
            valid_q <= 1'b0;
            run_q   <= 1'b0;
            cnt_q   <= '0;
         end else begin
            sh_q  <= {1'b0, sh_q[DATA_LEN-1:1]};
            cnt_q <= cnt_q + 1'b1;
         end
      end else if (valid_q && master_ready_i) begin
         run_q <= 1'b1;
      end
   end

   assign slave_valid_o = valid_q;
   assign tx_rdata_o    = sh_q[0];
   assign done_o        = run_q && (cnt_q == BIT_LAST);

endmodule

// File: rtl/slave_in_port.sv
// Slave-side bus input port. Deserialises LSB-first address/data streams
// after a master handshake, issues one memory write or read, and serialises
// read data back. Optional out-of-range address rejection is compiled in
// with SLAVE_ADDR_CHECK_EN.
module slave_in_port
   import slave_in_port_pkg::*;
#(
   parameter int ADDR_LEN  = ADDR_LEN_DEF,
   parameter int DATA_LEN  = DATA_LEN_DEF,
   parameter int MEM_DEPTH = 4096
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                master_valid,
   input  logic                write_en,
   input  logic                read_en,
   input  logic                rx_address,
   input  logic                rx_data,
   output logic                slave_ready,
   output logic [ADDR_LEN-1:0] mem_addr,
   output logic [DATA_LEN-1:0] mem_wdata,
   output logic                mem_we,
   output logic                mem_re,
   input  logic [DATA_LEN-1:0] mem_rdata,
   input  logic                mem_rvalid,
   output logic                slave_valid,
   output logic                tx_rdata,
   input  logic                master_ready,
   output logic                addr_error
);

   localparam int N  = max_len(ADDR_LEN, DATA_LEN);
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(N - 1);
   localparam logic [CW-1:0] CNT_A_LAST = CW'(ADDR_LEN - 1);
   localparam logic [CW-1:0] CNT_D_LAST = CW'(DATA_LEN - 1);
   // One extra bit so a depth equal to 2**ADDR_LEN is representable.
   localparam logic [ADDR_LEN:0] DEPTH_LIM = (ADDR_LEN + 1)'(MEM_DEPTH);

`ifdef SLAVE_ADDR_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   state_e              state_q;
   logic [1:0]          mode_q;
   logic [CW-1:0]       cnt_q;
   logic [ADDR_LEN-1:0] addr_sh_q;
   logic [DATA_LEN-1:0] data_sh_q;
   logic [ADDR_LEN-1:0] mem_addr_q;
   logic [DATA_LEN-1:0] mem_wdata_q;
   logic                mem_we_q;
   logic                mem_re_q;
   logic                slave_ready_q;
   logic                addr_ok;
   logic                ser_load;
   logic [DATA_LEN-1:0] ser_data;
   logic                ser_done;

   assign addr_ok = !CHK_EN || ({1'b0, addr_sh_q} < DEPTH_LIM);

`ifdef SLAVE_ADDR_CHECK_EN
   logic addr_error_q;
   assign addr_error = addr_error_q;
`else
   assign addr_error = 1'b0;
`endif

   // Serializer load: fresh memory data, or a zero word for a rejected read.
   always_comb begin
      ser_load = 1'b0;
      ser_data = '0;
      if (state_q == S_READ_REQ && !addr_ok) begin
         ser_load = 1'b1;
      end else if (state_q == S_READ_WAIT && mem_rvalid) begin
         ser_load = 1'b1;
         ser_data = mem_rdata;
      end
   end

   // Main transaction FSM with registered strobes and ready. The shift
   // registers shift right so that exactly ADDR_LEN / DATA_LEN shifts leave
   // the first (LSB) bit at index 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         mode_q        <= MODE_INACTIVE;
         cnt_q         <= '0;
         addr_sh_q     <= '0;
         data_sh_q     <= '0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         mem_we_q      <= 1'b0;
         mem_re_q      <= 1'b0;
         slave_ready_q <= 1'b1;
`ifdef SLAVE_ADDR_CHECK_EN
         addr_error_q  <= 1'b0;
`endif
      end else begin
         mem_we_q <= 1'b0;
         mem_re_q <= 1'b0;
`ifdef SLAVE_ADDR_CHECK_EN
         addr_error_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               slave_ready_q <= 1'b1;
               cnt_q         <= '0;
               if (master_valid && slave_ready_q && (write_en ^ read_en)) begin
                  mode_q        <= write_en ? MODE_WRITE : MODE_READ;
                  addr_sh_q     <= {rx_address, addr_sh_q[ADDR_LEN-1:1]};
                  data_sh_q     <= {rx_data, data_sh_q[DATA_LEN-1:1]};
                  cnt_q         <= CW'(1);
                  slave_ready_q <= 1'b0;
                  state_q       <= S_RX;
               end
            end
            S_RX: begin
               if (!master_valid) begin
                  // Master gave up mid-stream: drop everything, no access.
                  state_q       <= S_IDLE;
                  mode_q        <= MODE_INACTIVE;
                  cnt_q         <= '0;
                  slave_ready_q <= 1'b1;
               end else begin
                  if (cnt_q <= CNT_A_LAST) addr_sh_q <= {rx_address, addr_sh_q[ADDR_LEN-1:1]};
                  if (cnt_q <= CNT_D_LAST) data_sh_q <= {rx_data, data_sh_q[DATA_LEN-1:1]};
                  if (cnt_q == CNT_LAST) begin
                     state_q <= (mode_q == MODE_WRITE) ? S_WRITE_MEM : S_READ_REQ;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            S_WRITE_MEM: begin
               // Ready is restored by IDLE on the following edge.
               state_q <= S_IDLE;
               if (addr_ok) begin
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= addr_sh_q;
                  mem_wdata_q <= data_sh_q;
               end else begin
`ifdef SLAVE_ADDR_CHECK_EN
                  addr_error_q <= 1'b1;
`endif
               end
            end
            S_READ_REQ: begin
               if (addr_ok) begin
                  mem_re_q   <= 1'b1;
                  mem_addr_q <= addr_sh_q;
                  state_q    <= S_READ_WAIT;
               end else begin
`ifdef SLAVE_ADDR_CHECK_EN
                  addr_error_q <= 1'b1;
`endif
                  state_q <= S_TX_READ;
               end
            end
            S_READ_WAIT: begin
               // Also covers rvalid arriving together with mem_re.
               if (mem_rvalid) state_q <= S_TX_READ;
            end
            S_TX_READ: begin
               if (ser_done) begin
                  state_q       <= S_IDLE;
                  mode_q        <= MODE_INACTIVE;
                  slave_ready_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   slave_read_serializer #(.DATA_LEN(DATA_LEN)) u_ser (
      .clk            (clk),
      .reset          (reset),
      .load_i         (ser_load),
      .load_data_i    (ser_data),
      .master_ready_i (master_ready),
      .slave_valid_o  (slave_valid),
      .tx_rdata_o     (tx_rdata),
      .done_o         (ser_done)
   );

   assign slave_ready = slave_ready_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_we      = mem_we_q;
   assign mem_re      = mem_re_q;

endmodule
